dual_input_debounce: RTL and testbench
======================================

// Module: dual_input_debounce
// PURPOSE
//  Two-channel synchroniser + debouncer for raw switch/button inputs a_raw, b_raw.
//  Presents clean, glitch-free levels a_db, b_db to the downstream 2-input logic stages (nor/or/and gates).
//  Also emits a one-cycle change strobe.
//  Each channel is independent: 2-flop synchroniser, then a stability counter.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive cycles the synchronised input must differ from a_db/b_db before that output updates (>=1)
//  CNT_W          16  stability counter width; must satisfy STABLE_CYCLES <= 2**CNT_W
// PORTS
//  clk     in   1  single clock; all state on posedge
//  rst_n   in   1  asynchronous, active-low reset
//  a_raw   in   1  raw input A, asynchronous to clk
//  b_raw   in   1  raw input B, asynchronous to clk
//  a_db    out  1  debounced level A, registered
//  b_db    out  1  debounced level B, registered
//  chg     out  1  1-cycle pulse when a_db and/or b_db updates, registered
// BEHAVIOUR
//  Reset values (rst_n low, async):
//   - sync1, sync2, stable level, cnt: 0
//   - FSM state: IDLE
//   - outputs a_db, b_db, chg: 0
//  Per channel, each posedge:
//   - sync1 <= raw; sync2 <= sync1
//   - sync2 == stable: cnt <= 0; state IDLE
//   - sync2 != stable and cnt == STABLE_CYCLES-1: stable <= sync2; cnt <= 0; state IDLE; upd = 1
//   - otherwise: cnt <= cnt + 1; state COUNT
//  FSM:
//   - IDLE -> COUNT: first cycle sync2 != stable (skipped when STABLE_CYCLES = 1; update fires directly)
//   - COUNT -> IDLE: on mismatch expiry or on any return to match
//  Latency: raw stable from edge 0 -> output changes at edge STABLE_CYCLES+1 (edge 5 at default).
//  Glitch rejection: a pulse seen on sync2 for fewer than STABLE_CYCLES cycles clears cnt; no output change.
//  chg <= upd_a | upd_b.
//   - Both channels updating on the same edge give one pulse, not two.
//   - Updates on consecutive edges give chg high on each.
//  Counter never exceeds STABLE_CYCLES-1, so no wrap-around.
//  Reset mid-count discards progress; after release, outputs need a full new debounce period.
//  No handshake: outputs are plain levels; consumers sample a_db/b_db at any time.
// CONFIGURATION
//  DEBOUNCE_EDGE_EN defined:
//   - adds output ports a_rise, a_fall, b_rise, b_fall (1 bit each, reset 0)
//   - each is a 1-cycle pulse on the same edge the matching output goes 0->1 or 1->0
//  DEBOUNCE_EDGE_EN undefined:
//   - these ports and their flops do not exist
//   - all other behaviour is identical
// STRUCTURE
//  Package debounce_pkg:
//   - typedef enum logic {DB_IDLE, DB_COUNT} db_state_t
//   - localparam DB_SYNC_STAGES = 2
//  Sub-module debounce_ch, instantiated twice (A, B):
//   - ports: clk, rst_n, raw, level, upd, plus rise/fall under DEBOUNCE_EDGE_EN
//   - contains the synchroniser, counter and FSM
//  Top level: chg OR-reduction and port wiring only.
// TESTING
//  Use STABLE_CYCLES=4 throughout.
//  1. Reset: assert rst_n=0 mid-run -> a_db=b_db=chg=0 immediately, without waiting for a clock edge.
//  2. Clean step: a_raw 0->1 before edge 0, held -> a_db=1 and chg=1 at edge 5 only; b_db stays 0.
//  3. Glitch: b_raw high for 3 cycles, then low -> b_db stays 0, chg never asserts.
//  4. Near-miss: a_raw high 3 cycles, low 1 cycle, high again -> count restarts; a_db rises 5 edges after the final rise.
//  5. Simultaneous: a_raw and b_raw rise together -> a_db, b_db rise on the same edge with a single 1-cycle chg pulse.
//  6. Reset mid-count: rst_n low during COUNT, then released with raw still high -> output rises STABLE_CYCLES+1 edges after release.
//  With DEBOUNCE_EDGE_EN: rerun 2, then lower a_raw -> a_rise then a_fall, each 1 cycle, coincident with chg.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the dual-channel debouncer
package debounce_pkg;

    typedef enum logic {DB_IDLE, DB_COUNT} db_state_t;

    localparam int DB_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one channel: 2-flop synchroniser, stability counter and FSM
// DEBOUNCE_EDGE_EN adds registered rise/fall pulses aligned with the level update.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
`ifdef DEBOUNCE_EDGE_EN
    output logic rise,
    output logic fall,
`endif
    output logic upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [DB_SYNC_STAGES-1:0] sync;
    logic                      sync_out;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    db_state_t                 state, state_nxt;
    logic                      level_nxt;
    logic                      mismatch;
    logic                      expire;

    assign sync_out = sync[DB_SYNC_STAGES-1];
    assign mismatch = sync_out != level;
    // With a single-cycle window the update fires straight from IDLE.
    assign expire   = (cnt == CNT_LAST) && ((STABLE_CYCLES == 1) || (state == DB_COUNT));

    always_comb begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
        level_nxt = level;
        upd       = 1'b0;
        if (mismatch) begin
            if (expire) begin
                level_nxt = sync_out;
                upd       = 1'b1;
            end else begin
                cnt_nxt   = cnt + 1'b1;
                state_nxt = DB_COUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            state <= DB_IDLE;
            level <= 1'b0;
        end else begin
            sync  <= {sync[DB_SYNC_STAGES-2:0], raw};
            cnt   <= cnt_nxt;
            state <= state_nxt;
            level <= level_nxt;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= upd & sync_out;
            fall <= upd & ~sync_out;
        end
    end
`endif

endmodule

// File: rtl/dual_input_debounce.sv
// rtl/dual_input_debounce.sv - two independent debounce channels with a shared change strobe
// DEBOUNCE_EDGE_EN exposes per-channel rise/fall pulses.
module dual_input_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db,
`ifdef DEBOUNCE_EDGE_EN
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
`endif
    output logic chg
);

    logic upd_a, upd_b;

    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_ch_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .level (a_db),
`ifdef DEBOUNCE_EDGE_EN
        .rise  (a_rise),
        .fall  (a_fall),
`endif
        .upd   (upd_a)
    );

    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .level (b_db),
`ifdef DEBOUNCE_EDGE_EN
        .rise  (b_rise),
        .fall  (b_fall),
`endif
        .upd   (upd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chg <= 1'b0;
        else        chg <= upd_a | upd_b;
    end

endmodule

// File: tb/tb_dual_input_debounce.sv
// tb/tb_dual_input_debounce.sv - directed self-checking bench for dual_input_debounce (STABLE_CYCLES=4)
module tb_dual_input_debounce;

    logic clk = 1'b0;
    logic rst_n, a_raw, b_raw;
    logic a_db, b_db, chg;
`ifdef DEBOUNCE_EDGE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dual_input_debounce #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_db   (a_db),
        .b_db   (b_db),
`ifdef DEBOUNCE_EDGE_EN
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall),
`endif
        .chg    (chg)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick(3);
        check("rst_a_db", a_db, 1'b0);
        check("rst_b_db", b_db, 1'b0);
        check("rst_chg",  chg,  1'b0);
        rst_n = 1'b1;
        tick(3);

        // Clean step on A: update lands on edge 5 (the 6th tick).
        a_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("step_a_db", a_db, i >= 6);
            check("step_chg",  chg,  i == 6);
            check("step_b_db", b_db, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
            check("step_a_rise", a_rise, i == 6);
            check("step_a_fall", a_fall, 1'b0);
`endif
        end

`ifdef DEBOUNCE_EDGE_EN
        a_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("fall_a_db",   a_db,   i < 6);
            check("fall_chg",    chg,    i == 6);
            check("fall_a_fall", a_fall, i == 6);
            check("fall_a_rise", a_rise, 1'b0);
        end
        a_raw = 1'b1;
        tick(8);
        check("refill_a_db", a_db, 1'b1);
`endif

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        a_raw = 1'b0;
        rst_n = 1'b0;
        #2;
        check("async_rst_a_db", a_db, 1'b0);
        check("async_rst_b_db", b_db, 1'b0);
        check("async_rst_chg",  chg,  1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Glitch on B: three cycles high is rejected.
        b_raw = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            if (i == 4) b_raw = 1'b0;
            tick(1);
            check("glitch_b_db", b_db, 1'b0);
            check("glitch_chg",  chg,  1'b0);
        end

        // Near-miss on A: 3 high, 1 low, then high again restarts the count.
        a_raw = 1'b1;
        tick(3);
        a_raw = 1'b0;
        tick(1);
        check("near_a_db_pre", a_db, 1'b0);
        a_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("near_a_db", a_db, i >= 6);
            check("near_chg",  chg,  i == 6);
        end
        a_raw = 1'b0;
        tick(8);
        check("near_a_db_back", a_db, 1'b0);

        // Simultaneous rise: one shared chg pulse.
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("sim_a_db", a_db, i >= 6);
            check("sim_b_db", b_db, i >= 6);
            check("sim_chg",  chg,  i == 6);
        end

        // Reset during COUNT, released with A still high: full new debounce period.
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick(8);
        a_raw = 1'b1;
        tick(4);
        check("midcnt_a_db_pre", a_db, 1'b0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("midcnt_a_db", a_db, i >= 6);
            check("midcnt_chg",  chg,  i == 6);
            check("midcnt_b_db", b_db, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
